intra_net_requant_wb: RTL and testbench

- Write-back stage between the output buffer and the activation buffer inside the intra-network path.
- Reads 32-bit signed accumulator rows from the output buffer and requantizes each column: round, arithmetic shift, optional ReLU, saturate to signed 8 bit.
- Writes the resulting rows into the activation buffer.
- Owns its own row counter, read/write address generation and a two-stage data pipeline; a start pulse launches one transfer and a done pulse reports completion.

---
 rtl/intra_net_requant_wb_if.sv | 32 +++
 rtl/intra_net_requant_wb.sv | 110 +++++++++++
 tb/tb_intra_net_requant_wb.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intra_net_requant_wb_if.sv
// intra_net_requant_wb_if: launch/config, output-buffer read and activation-buffer write signals
interface intra_net_requant_wb_if #(
  parameter int ACT_DATA_WIDTH = 8,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_DIM = 16,
  parameter int SHIFT_WIDTH = 5
);
  logic start;
  logic [ADDR_WIDTH-1:0] num_rows;
  logic [COL_DIM-1:0] col_mask;
  logic [ADDR_WIDTH-1:0] O_base_addr;
  logic [ADDR_WIDTH-1:0] A_base_addr;
  logic [SHIFT_WIDTH-1:0] shift;
  logic relu_en;
  logic O_rd_en;
  logic [ADDR_WIDTH-1:0] O_addr;
  logic [COL_DIM*ACC_DATA_WIDTH-1:0] O_rdata;
  logic [COL_DIM-1:0] A_w_en;
  logic [ADDR_WIDTH-1:0] A_addr;
  logic [COL_DIM*ACT_DATA_WIDTH-1:0] A_wdata;
  logic busy;
  logic done;
  modport master (
    output start, num_rows, col_mask, O_base_addr, A_base_addr, shift, relu_en, O_rdata,
    input O_rd_en, O_addr, A_w_en, A_addr, A_wdata, busy, done
  );
  modport slave (
    input start, num_rows, col_mask, O_base_addr, A_base_addr, shift, relu_en, O_rdata,
    output O_rd_en, O_addr, A_w_en, A_addr, A_wdata, busy, done
  );
endinterface

// File: rtl/intra_net_requant_wb.sv
// intra_net_requant_wb: streams accumulator rows out of the output buffer, requantizes them and writes the activation buffer
module intra_net_requant_wb #(
  parameter int ACT_DATA_WIDTH = 8,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int COL_DIM = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  intra_net_requant_wb_if.slave bus
);
  localparam int AW = ACC_DATA_WIDTH + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACT_DATA_WIDTH+1){1'b0}}, {(ACT_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACT_DATA_WIDTH+1){1'b1}}, {(ACT_DATA_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, num_rows_q, o_base_q, a_base_q, a_addr_q;
  logic [COL_DIM-1:0] col_mask_q, a_w_en_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic relu_q, v1_q, accept;
  logic [COL_DIM*ACT_DATA_WIDTH-1:0] wdata_d, a_wdata_q;

  function automatic logic [ACT_DATA_WIDTH-1:0] requant(
    input logic [ACC_DATA_WIDTH-1:0] acc,
    input logic [SHIFT_WIDTH-1:0] sh,
    input logic relu
  );
    logic [AW-1:0] rnd;
    logic signed [AW-1:0] r;
    rnd = (sh != '0) ? (AW'(1) << (sh - 1'b1)) : '0;
    r = $signed({acc[ACC_DATA_WIDTH-1], acc}) + $signed(rnd);
    r = r >>> sh;
    if (relu && r[AW-1]) r = '0;
    return (r > SAT_MAX) ? SAT_MAX[ACT_DATA_WIDTH-1:0] :
           (r < SAT_MIN) ? SAT_MIN[ACT_DATA_WIDTH-1:0] : r[ACT_DATA_WIDTH-1:0];
  endfunction

  assign accept = (state_q == IDLE) && bus.start;
  assign bus.O_rd_en = state_q == READ;
  assign bus.O_addr = bus.O_rd_en ? o_base_q + rd_cnt_q : '0;
  assign bus.busy = (state_q == READ || state_q == DRAIN) && num_rows_q != '0;
  assign bus.done = state_q == DONE;
  assign bus.A_w_en = a_w_en_q;
  assign bus.A_addr = a_addr_q;
  assign bus.A_wdata = a_wdata_q;

  // Next state and read counter; an empty transfer passes through DRAIN so done lands two cycles after start
  always_comb begin
    state_d = state_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = (bus.num_rows == '0) ? DRAIN : READ;
        rd_cnt_d = '0;
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == num_rows_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: if (!v1_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Requantize every column of the row arriving from the output buffer
  always_comb begin
    wdata_d = '0;
    for (int c = 0; c < COL_DIM; c++)
      wdata_d[c*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = requant(bus.O_rdata[c*ACC_DATA_WIDTH +: ACC_DATA_WIDTH], shift_q, relu_q);
  end

  // State, latched configuration and the read-valid / write-register pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      num_rows_q <= '0;
      o_base_q <= '0;
      a_base_q <= '0;
      col_mask_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      v1_q <= 1'b0;
      a_w_en_q <= '0;
      a_addr_q <= '0;
      a_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      v1_q <= state_q == READ;
      a_w_en_q <= v1_q ? col_mask_q : '0;
      if (accept) begin
        num_rows_q <= bus.num_rows;
        o_base_q <= bus.O_base_addr;
        a_base_q <= bus.A_base_addr;
        col_mask_q <= bus.col_mask;
        shift_q <= bus.shift;
        relu_q <= bus.relu_en;
        wr_cnt_q <= '0;
      end
      if (v1_q) begin
        a_addr_q <= a_base_q + wr_cnt_q;
        a_wdata_q <= wdata_d;
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_intra_net_requant_wb.sv
// tb_intra_net_requant_wb: randomized scenario bench with a behavioural requant and timeline model
module tb_intra_net_requant_wb;
  logic clk, reset;
  int tests_run, fails;
  logic [511:0] omem [1024];
  logic rec_rd [64], rec_busy [64], rec_done [64];
  logic [9:0] rec_oaddr [64], rec_aaddr [64];
  logic [15:0] rec_wen [64];
  logic [127:0] rec_wdata [64];

  intra_net_requant_wb_if bus();
  intra_net_requant_wb dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-buffer model: data appears one cycle after the read strobe
  always @(posedge clk) bus.O_rdata <= bus.O_rd_en ? omem[bus.O_addr] : {16{32'hA5A5_5A5A}};

  function automatic logic [7:0] rq(input logic signed [31:0] acc, input int sh, input bit relu);
    longint v;
    v = longint'(acc);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic logic [127:0] exp_row(input logic [511:0] row, input int sh, input bit relu);
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[c*8 +: 8] = rq(row[c*32 +: 32], sh, relu);
    return r;
  endfunction

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($urandom_range(0, 4000)) - 32'd2000;
      2: return 32'h7FFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic fill(input logic [9:0] ob, input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 16; c++) omem[10'(ob + i)][c*32 +: 32] = rand_acc();
  endtask

  task automatic run(input int n, input logic [9:0] ob, input logic [9:0] ab, input int sh, input bit relu,
                     input logic [15:0] mask, input int ncyc, input int re1, input int re2);
    @(posedge clk); #1;
    bus.num_rows = 10'(n);
    bus.O_base_addr = ob;
    bus.A_base_addr = ab;
    bus.shift = 5'(sh);
    bus.relu_en = relu;
    bus.col_mask = mask;
    bus.start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      rec_rd[k] = bus.O_rd_en;
      rec_oaddr[k] = bus.O_addr;
      rec_wen[k] = bus.A_w_en;
      rec_aaddr[k] = bus.A_addr;
      rec_wdata[k] = bus.A_wdata;
      rec_busy[k] = bus.busy;
      rec_done[k] = bus.done;
      @(posedge clk); #1;
      bus.start = (k + 1 == re1) || (k + 1 == re2);
      bus.num_rows = bus.start ? 10'd1 : 10'($urandom());
      bus.O_base_addr = 10'($urandom());
      bus.A_base_addr = 10'($urandom());
      bus.shift = 5'($urandom());
      bus.relu_en = 1'($urandom());
      bus.col_mask = 16'($urandom());
    end
    bus.start = 1'b0;
  endtask

  task automatic test_transfer(input string name, input int n, input logic [9:0] ob, input logic [9:0] ab,
                               input int sh, input bit relu, input logic [15:0] mask);
    int ncyc;
    bit er, ew, eb, ed;
    logic [9:0] eo, ea;
    logic [127:0] edata;
    ncyc = n + 6;
    run(n, ob, ab, sh, relu, mask, ncyc, -1, -1);
    for (int k = 0; k < ncyc; k++) begin
      er = n > 0 && k >= 1 && k <= n;
      ew = n > 0 && k >= 3 && k <= n + 2;
      eb = n > 0 && k >= 1 && k <= n + 2;
      ed = (n > 0) ? (k == n + 3) : (k == 2);
      eo = er ? 10'(ob + k - 1) : 10'd0;
      tests_run++;
      if ({rec_rd[k], rec_oaddr[k], rec_wen[k], rec_busy[k], rec_done[k]} !== {er, eo, (ew ? mask : 16'h0), eb, ed}) begin
        fails++;
        $display("FAIL %s cyc%0d rd/oaddr/wen/busy/done got %b/%h/%h/%b/%b want %b/%h/%h/%b/%b", name, k,
                 rec_rd[k], rec_oaddr[k], rec_wen[k], rec_busy[k], rec_done[k], er, eo, (ew ? mask : 16'h0), eb, ed);
      end
      if (ew) begin
        ea = 10'(ab + k - 3);
        edata = exp_row(omem[10'(ob + k - 3)], sh, relu);
        tests_run++;
        if ({rec_aaddr[k], rec_wdata[k]} !== {ea, edata}) begin
          fails++;
          $display("FAIL %s cyc%0d write addr/data got %h/%h want %h/%h", name, k, rec_aaddr[k], rec_wdata[k], ea, edata);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.A_addr, bus.A_wdata, bus.busy, bus.done} !== '0) begin
      fails++;
      $display("FAIL reset_hold outputs got %b/%h/%h/%h/%h/%b/%b want all 0", bus.O_rd_en, bus.O_addr, bus.A_w_en,
               bus.A_addr, bus.A_wdata, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.A_addr, bus.A_wdata, bus.busy, bus.done} !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d outputs nonzero: rd %b oaddr %h wen %h busy %b done %b want all 0",
                 k, bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 16; c++) omem[10'h010 + 10'(i)][c*32 +: 32] = 32'(c - 8);
    test_transfer("basic", 4, 10'h010, 10'h200, 0, 1'b0, 16'hFFFF);
    for (int k = 3; k <= 6; k++) begin
      tests_run++;
      if ({rec_wdata[k][7:0], rec_wdata[k][127:120]} !== 16'hF807) begin
        fails++;
        $display("FAIL basic_cols cyc%0d col0/col15 got %h/%h want f8/07", k, rec_wdata[k][7:0], rec_wdata[k][127:120]);
      end
    end
  endtask

  task automatic test_round_sat();
    logic [511:0] row;
    logic [31:0] acc [5];
    logic [7:0] want [5];
    acc = '{32'd24, -32'sd24, 32'd100000, -32'sd100000, 32'h7FFF_FFFF};
    want = '{8'h02, 8'hFF, 8'h7F, 8'h80, 8'h7F};
    fill(10'h155, 1);
    row = omem[10'h155];
    for (int c = 0; c < 5; c++) row[c*32 +: 32] = acc[c];
    omem[10'h155] = row;
    test_transfer("round_sat", 1, 10'h155, 10'h0AA, 4, 1'b0, 16'hFFFF);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (rec_wdata[3][c*8 +: 8] !== want[c]) begin
        fails++;
        $display("FAIL round_sat col%0d got %h want %h", c, rec_wdata[3][c*8 +: 8], want[c]);
      end
    end
  endtask

  task automatic test_relu_mask();
    logic [511:0] row;
    fill(10'h020, 2);
    for (int i = 0; i < 2; i++) begin
      row = omem[10'h020 + 10'(i)];
      row[4*32 +: 32] = -32'sd40;
      row[5*32 +: 32] = 32'd40;
      omem[10'h020 + 10'(i)] = row;
    end
    test_transfer("relu_mask", 2, 10'h020, 10'h300, 2, 1'b1, 16'h00F0);
    tests_run++;
    if (rec_wdata[3][47:32] !== 16'h0A00) begin
      fails++;
      $display("FAIL relu_cols col5/col4 got %h want 0a00", rec_wdata[3][47:32]);
    end
  endtask

  task automatic test_boundaries();
    test_transfer("zero_rows", 0, 10'h100, 10'h100, 3, 1'b0, 16'hFFFF);
    fill(10'h3FE, 3);
    test_transfer("addr_wrap", 3, 10'h3FE, 10'h3FF, 1, 1'b0, 16'hFFFF);
  endtask

  task automatic test_back_to_back();
    int nw, nd, nr;
    bit seen;
    fill(10'h040, 3);
    run(3, 10'h040, 10'h040, 0, 1'b0, 16'hFFFF, 10, 2, 6);
    nw = 0; nd = 0; nr = 0;
    for (int k = 0; k < 10; k++) begin
      nw += int'(rec_wen[k] != 16'h0);
      nd += int'(rec_done[k]);
      nr += int'(rec_rd[k]);
    end
    tests_run++;
    if (nw != 3 || nd != 1 || nr != 3) begin
      fails++;
      $display("FAIL b2b_ignored writes/dones/reads got %0d/%0d/%0d want 3/1/3", nw, nd, nr);
    end
    fill(10'h050, 2);
    run(2, 10'h050, 10'h050, 0, 1'b0, 16'hFFFF, 8, 6, -1);
    tests_run++;
    if ({rec_done[5], rec_rd[6], rec_rd[7]} !== 3'b101) begin
      fails++;
      $display("FAIL b2b_after_done done5/rd6/rd7 got %b%b%b want 101", rec_done[5], rec_rd[6], rec_rd[7]);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL b2b_second_done got no done within 20 cycles want done");
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int nw, nd;
    fill(10'h080, 8);
    run(8, 10'h080, 10'h180, 0, 1'b0, 16'hFFFF, 5, -1, -1);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.A_addr, bus.A_wdata, bus.busy, bus.done} !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs got rd %b oaddr %h wen %h aaddr %h busy %b done %b want all 0",
               bus.O_rd_en, bus.O_addr, bus.A_w_en, bus.A_addr, bus.busy, bus.done);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    nw = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      nw += int'(bus.A_w_en != 16'h0);
      nd += int'(bus.done);
    end
    tests_run++;
    if (nw != 0 || nd != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet writes/dones got %0d/%0d want 0/0", nw, nd);
    end
    fill(10'h0C0, 2);
    test_transfer("after_reset", 2, 10'h0C0, 10'h1C0, 5, 1'b1, 16'hFFFF);
  endtask

  task automatic test_random();
    int n, sh;
    logic [9:0] ob, ab;
    bit relu;
    logic [15:0] mask;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 12);
      ob = 10'($urandom());
      ab = 10'($urandom());
      sh = $urandom_range(0, 31);
      relu = 1'($urandom());
      mask = 16'($urandom_range(1, 16'hFFFF));
      fill(ob, n);
      test_transfer($sformatf("random%0d", it), n, ob, ab, sh, relu, mask);
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    for (int i = 0; i < 1024; i++) omem[i] = '0;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.col_mask = '0;
    bus.O_base_addr = '0;
    bus.A_base_addr = '0;
    bus.shift = '0;
    bus.relu_en = 1'b0;
    test_reset();
    test_basic();
    test_round_sat();
    test_relu_mask();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
